uart_tx_sequencer: RTL

Frame controller for the UART transmit path.
- Owns and configures the baud divisor consumed by the baud-rate generator.
- Resynchronises the generator at frame start.
- Sequences start, data, optional parity and stop bits onto the serial line, one bit per OVERSAMPLE generator ticks.
- Accepts bytes from upstream logic via a valid/ready handshake and rejects configuration changes while a frame is in flight.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_tx_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encodings and frame-configuration type for the UART transmit path.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam logic [15:0] DEFAULT_DIV = 16'd326;

  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  typedef struct packed {
    logic parity_en;
    logic parity_odd;
    logic two_stop;
  } frame_cfg_t;

  localparam frame_cfg_t CFG_DEFAULT = '{parity_en: 1'b0, parity_odd: 1'b0, two_stop: 1'b0};

endpackage

// File: rtl/uart_bit_timer.sv
// Counts generator ticks within a serial bit and bits within the current frame phase.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_tick,
  input  logic             i_enable,
  output logic             o_bit_end,
  output logic [BIT_W-1:0] o_bit_idx
);

  logic [TICK_W-1:0] r_tickCnt;
  logic [BIT_W-1:0]  r_bitIdx;

  assign o_bit_end = i_enable && i_tick && (r_tickCnt == TICK_W'(OVERSAMPLE - 1));
  assign o_bit_idx = r_bitIdx;

  // Clear wins over counting so a phase change always restarts the bit index at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_tickCnt <= '0;
      r_bitIdx  <= '0;
    end else if (i_enable && i_tick) begin
      if (o_bit_end) begin
        r_tickCnt <= '0;
        r_bitIdx  <= r_bitIdx + BIT_W'(1);
      end else begin
        r_tickCnt <= r_tickCnt + TICK_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit frame controller: owns the baud divisor and sequences start/data/parity/stop bits.
module uart_tx_sequencer
  import uart_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tick,
  output logic                 o_gen_reset,
  output logic [15:0]          o_baud_div,
  input  logic                 i_cfg_we,
  input  logic [15:0]          i_cfg_div,
  input  logic                 i_cfg_parity_en,
  input  logic                 i_cfg_parity_odd,
  input  logic                 i_cfg_two_stop,
  output logic                 o_cfg_err,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx,
  output logic                 o_busy
);

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parityBit;
  frame_cfg_t           r_frameCfg;
  frame_cfg_t           r_cfg;
  logic [15:0]          r_baudDiv;
  logic                 r_tx;
  logic                 r_genReset;
  logic                 r_cfgErr;

  logic                 w_accept;
  logic                 w_cfgOk;
  logic                 w_cfgReject;
  logic                 w_bitEnd;
  logic [BIT_W-1:0]     w_bitIdx;
  logic                 w_lastData;
  logic                 w_lastStop;
  logic                 w_timerClear;
  logic [DATA_BITS-1:0] w_shiftNext;

  assign o_tx_ready  = (r_state == IDLE) && !i_cfg_we;
  assign w_accept    = i_tx_valid && o_tx_ready;
  assign w_cfgOk     = i_cfg_we && (r_state == IDLE) && (i_cfg_div != 16'd0);
  assign w_cfgReject = i_cfg_we && !w_cfgOk;

  assign w_lastData  = (w_bitIdx == BIT_W'(DATA_BITS - 1));
  assign w_lastStop  = !r_frameCfg.two_stop || (w_bitIdx == BIT_W'(1));
  assign w_shiftNext = {1'b0, r_shift[DATA_BITS-1:1]};

  // The bit index counts within a phase, so restart it on every state change.
  assign w_timerClear = w_accept ||
                        (w_bitEnd && !(((r_state == DATA) && !w_lastData) ||
                                       ((r_state == STOP) && !w_lastStop)));

  uart_bit_timer u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_timerClear),
    .i_tick    (i_tick),
    .i_enable  (r_state != IDLE),
    .o_bit_end (w_bitEnd),
    .o_bit_idx (w_bitIdx)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_parityBit <= 1'b0;
      r_frameCfg  <= CFG_DEFAULT;
      r_cfg       <= CFG_DEFAULT;
      r_baudDiv   <= DEFAULT_DIV;
      r_tx        <= 1'b1;
      r_genReset  <= 1'b0;
      r_cfgErr    <= 1'b0;
    end else begin
      r_genReset <= w_accept || w_cfgOk;
      r_cfgErr   <= w_cfgReject;
      if (w_cfgOk) begin
        r_baudDiv <= i_cfg_div;
        r_cfg     <= '{parity_en: i_cfg_parity_en, parity_odd: i_cfg_parity_odd,
                       two_stop: i_cfg_two_stop};
      end
      // Each bit end drives the next bit on the same edge, so bit boundaries are tick-exact.
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift     <= i_tx_data;
            r_frameCfg  <= r_cfg;
            r_parityBit <= (^i_tx_data) ^ r_cfg.parity_odd;
            r_tx        <= 1'b0;
            r_state     <= START;
          end
        end
        START: begin
          if (w_bitEnd) begin
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_bitEnd) begin
            if (!w_lastData) begin
              r_shift <= w_shiftNext;
              r_tx    <= w_shiftNext[0];
            end else if (r_frameCfg.parity_en) begin
              r_tx    <= r_parityBit;
              r_state <= PARITY;
            end else begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end
          end
        end
        PARITY: begin
          if (w_bitEnd) begin
            r_tx    <= 1'b1;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_bitEnd && w_lastStop) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_gen_reset = r_genReset;
  assign o_baud_div  = r_baudDiv;
  assign o_cfg_err   = r_cfgErr;
  assign o_tx        = r_tx;
  assign o_busy      = (r_state != IDLE);

endmodule
